// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 frame receiver.
//   - receiver FSM state type
//   - scan-code prefix bytes (extended, break)
//   - frame length in bits (start + 8 data + parity + stop)
//   - frame_good(): odd parity over data+parity, stop bit high
package ps2_pkg;

   localparam logic [7:0]  PS2_EXT   = 8'hE0;
   localparam logic [7:0]  PS2_BRK   = 8'hF0;
   localparam int unsigned FRAME_LEN = 11;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StCheck
   } ps2_state_e;

   // bits[7:0] data, bits[8] parity, bits[9] stop
   function automatic logic frame_good(input logic [9:0] bits);
      return (^bits[8:0]) & bits[9];
   endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if: bundle between a PS/2 keyboard side and the frame receiver.
//   ps2_clk, ps2_data : raw PS/2 lines (keyboard -> receiver)
//   code[7:0]         : last decoded scan code
//   ext, brk          : E0 / F0 prefix seen before code
//   code_valid        : one-cycle pulse when code/ext/brk update
//   frame_err         : one-cycle pulse on bad frame or timeout
// master = keyboard/host side, slave = receiver.
interface ps2_frame_rx_if;

   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] code;
   logic       ext;
   logic       brk;
   logic       code_valid;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  code, ext, brk, code_valid, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output code, ext, brk, code_valid, frame_err
   );

endinterface

// File: rtl/ps2_filter.sv
// ps2_filter: 2-flop synchronizer followed by a glitch filter for one PS/2 line.
//   clk, rst : system clock, asynchronous active-high reset
//   i_raw    : raw asynchronous input
//   o_filt   : filtered level; follows the synchronized input only after
//              FILTER_LEN consecutive samples that differ from the current level
// Everything resets to 1, the PS/2 idle level.
module ps2_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_filt
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_filt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= 2'b11;
         r_cnt  <= '0;
         r_filt <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         // Any sample matching the current level restarts the run.
         if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_filt = r_filt;

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 keyboard frame receiver and scan-code prefix decoder.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : ps2_frame_rx_if.slave -- raw ps2_clk/ps2_data in; code, ext, brk,
//              code_valid and frame_err out
// Parameters: FILTER_LEN (glitch filter length), TIMEOUT_CYC (abort an
// in-progress frame after this many cycles without a clock falling edge).
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input logic           clk,
   input logic           rst,
   ps2_frame_rx_if.slave bus
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic w_clk_f, w_data_f, w_fall;
   logic r_clk_prev;

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (bus.ps2_clk),
      .o_filt (w_clk_f)
   );

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (bus.ps2_data),
      .o_filt (w_data_f)
   );

   assign w_fall = r_clk_prev & ~w_clk_f;

   ps2_state_e    r_state, w_state_d;
   logic [3:0]    r_bit_cnt, w_bit_cnt_d;
   logic [9:0]    r_shift, w_shift_d, w_frame;
   logic [TW-1:0] r_to, w_to_d;
   logic          r_ext_pend, w_ext_pend_d, r_brk_pend, w_brk_pend_d;
   logic [7:0]    r_code, w_code_d;
   logic          r_ext, w_ext_d, r_brk, w_brk_d;
   logic          r_valid, w_valid_d, r_err, w_err_d;

   // Shift register contents including the bit sampled this cycle.
   assign w_frame = {w_data_f, r_shift[9:1]};

   always_comb begin
      w_state_d    = r_state;
      w_bit_cnt_d  = r_bit_cnt;
      w_shift_d    = r_shift;
      w_to_d       = r_to;
      w_ext_pend_d = r_ext_pend;
      w_brk_pend_d = r_brk_pend;
      w_code_d     = r_code;
      w_ext_d      = r_ext;
      w_brk_d      = r_brk;
      w_valid_d    = 1'b0;
      w_err_d      = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_to_d      = '0;
            w_bit_cnt_d = '0;
            if (w_fall && !w_data_f) begin
               w_state_d   = StRecv;
               w_bit_cnt_d = 4'd1;
            end
         end
         StRecv: begin
            if (w_fall) begin
               w_to_d      = '0;
               w_shift_d   = w_frame;
               w_bit_cnt_d = r_bit_cnt + 4'd1;
               // Outputs are registered here on the stop-bit edge so they
               // are visible during the CHECK cycle.
               if (r_bit_cnt == 4'(FRAME_LEN - 1)) begin
                  w_state_d = StCheck;
                  if (!frame_good(w_frame)) begin
                     w_err_d      = 1'b1;
                     w_ext_pend_d = 1'b0;
                     w_brk_pend_d = 1'b0;
                  end else if (w_frame[7:0] == PS2_EXT) begin
                     w_ext_pend_d = 1'b1;
                  end else if (w_frame[7:0] == PS2_BRK) begin
                     w_brk_pend_d = 1'b1;
                  end else begin
                     w_code_d     = w_frame[7:0];
                     w_ext_d      = r_ext_pend;
                     w_brk_d      = r_brk_pend;
                     w_valid_d    = 1'b1;
                     w_ext_pend_d = 1'b0;
                     w_brk_pend_d = 1'b0;
                  end
               end
            end else if (r_to == TW'(TIMEOUT_CYC - 1)) begin
               w_state_d    = StIdle;
               w_bit_cnt_d  = '0;
               w_to_d       = '0;
               w_err_d      = 1'b1;
               w_ext_pend_d = 1'b0;
               w_brk_pend_d = 1'b0;
            end else begin
               w_to_d = r_to + TW'(1);
            end
         end
         StCheck: begin
            w_state_d   = StIdle;
            w_bit_cnt_d = '0;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_to       <= '0;
         r_clk_prev <= 1'b1;
         r_ext_pend <= 1'b0;
         r_brk_pend <= 1'b0;
         r_code     <= 8'h00;
         r_ext      <= 1'b0;
         r_brk      <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_bit_cnt  <= w_bit_cnt_d;
         r_shift    <= w_shift_d;
         r_to       <= w_to_d;
         r_clk_prev <= w_clk_f;
         r_ext_pend <= w_ext_pend_d;
         r_brk_pend <= w_brk_pend_d;
         r_code     <= w_code_d;
         r_ext      <= w_ext_d;
         r_brk      <= w_brk_d;
         r_valid    <= w_valid_d;
         r_err      <= w_err_d;
      end
   end

   assign bus.code       = r_code;
   assign bus.ext        = r_ext;
   assign bus.brk        = r_brk;
   assign bus.code_valid = r_valid;
   assign bus.frame_err  = r_err;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: self-checking bench for ps2_frame_rx.
// Drives PS/2 frames bit by bit, counts code_valid/frame_err pulses with a
// monitor, and compares against a table of fixed vectors, hand-written corner
// sequences and a scan-code model fed with random frames.
module tb_ps2_frame_rx;

   localparam int unsigned FLEN = 8;
   localparam int unsigned TOUT = 300;
   localparam int          HALF = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ps2_frame_rx_if bus ();

   ps2_frame_rx #(
      .FILTER_LEN  (FLEN),
      .TIMEOUT_CYC (TOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_err   = 0;
   int cyc     = 0;
   int err_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.code_valid) n_valid <= n_valid + 1;
         if (bus.frame_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
         end
      end
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Scan-code model: prefix bytes set pending flags, anything else is a code.
   logic [7:0] m_code = 8'h00;
   bit m_ext = 0, m_brk = 0, m_ext_pend = 0, m_brk_pend = 0;

   task automatic model_frame(input logic [7:0] d, input bit bad_par,
                              output int ev, output int ee);
      ev = 0;
      ee = 0;
      if (bad_par) begin
         ee = 1;
         m_ext_pend = 0;
         m_brk_pend = 0;
      end else if (d == 8'hE0) begin
         m_ext_pend = 1;
      end else if (d == 8'hF0) begin
         m_brk_pend = 1;
      end else begin
         ev = 1;
         m_code = d;
         m_ext = m_ext_pend;
         m_brk = m_brk_pend;
         m_ext_pend = 0;
         m_brk_pend = 0;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Data set while clock is high; keyboard pulls the clock low mid-bit.
   task automatic ps2_bit(input bit b, input bit glitch);
      bus.ps2_data = b;
      if (glitch) begin
         wait_cyc(12);
         bus.ps2_clk = 1'b0;
         wait_cyc(3);
         bus.ps2_clk = 1'b1;
         wait_cyc(HALF - 15);
      end else begin
         wait_cyc(HALF);
      end
      bus.ps2_clk = 1'b0;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits,
                             input int gbit);
      logic [10:0] fr;
      fr = {1'b1, ~(^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == gbit);
      bus.ps2_data = 1'b1;
   endtask

   task automatic run_and_check(input logic [7:0] d, input bit bad_par, input int gbit,
                                input string nm, input int ev, input int ee,
                                input logic [7:0] ecode, input bit eext, input bit ebrk);
      int v0, e0;
      v0 = n_valid;
      e0 = n_err;
      send_frame(d, bad_par, 11, gbit);
      wait_cyc(60);
      chk({nm, " valid_cnt"}, n_valid - v0, ev);
      chk({nm, " err_cnt"}, n_err - e0, ee);
      chk({nm, " code"}, int'(bus.code), int'(ecode));
      chk({nm, " ext"}, int'(bus.ext), int'(eext));
      chk({nm, " brk"}, int'(bus.brk), int'(ebrk));
   endtask

   task automatic run_frame(input logic [7:0] d, input bit bad_par, input int gbit,
                            input string nm);
      int ev, ee;
      model_frame(d, bad_par, ev, ee);
      run_and_check(d, bad_par, gbit, nm, ev, ee, m_code, m_ext, m_brk);
   endtask

   typedef struct {
      logic [7:0] d;
      bit         bad_par;
      int         ev;
      int         ee;
      logic [7:0] code;
      bit         ext;
      bit         brk;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int ev, ee, v0, e0, lat, dly, t_end;
      logic [7:0] d;
      bit bp;

      vecs[0] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
      vecs[1] = '{8'hE0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
      vecs[2] = '{8'hF0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
      vecs[3] = '{8'h6B, 1'b0, 1, 0, 8'h6B, 1'b1, 1'b1};
      vecs[4] = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
      vecs[5] = '{8'h74, 1'b1, 0, 1, 8'h1C, 1'b0, 1'b0};
      vecs[6] = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b0, 1'b0};
      vecs[7] = '{8'hE0, 1'b0, 0, 0, 8'h75, 1'b0, 1'b0};
      vecs[8] = '{8'h12, 1'b1, 0, 1, 8'h75, 1'b0, 1'b0};
      vecs[9] = '{8'h34, 1'b0, 1, 0, 8'h34, 1'b0, 1'b0};

      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      rst = 1'b1;
      wait_cyc(5);
      chk("reset code", int'(bus.code), 0);
      chk("reset ext", int'(bus.ext), 0);
      chk("reset brk", int'(bus.brk), 0);
      chk("reset valid", int'(bus.code_valid), 0);
      chk("reset err", int'(bus.frame_err), 0);
      rst = 1'b0;
      wait_cyc(20);

      for (int i = 0; i < 10; i++) begin
         model_frame(vecs[i].d, vecs[i].bad_par, ev, ee);
         run_and_check(vecs[i].d, vecs[i].bad_par, -1, $sformatf("vec%0d", i),
                       vecs[i].ev, vecs[i].ee, vecs[i].code, vecs[i].ext, vecs[i].brk);
      end

      // Latency: 2 sync flops + FILTER_LEN filter samples + edge-detect cycle,
      // code_valid registered one clk later -> 11th posedge after the raw fall.
      begin
         logic [10:0] fr;
         d = 8'h3C;
         fr = {1'b1, ~(^d), d, 1'b0};
         v0 = n_valid;
         for (int i = 0; i < 10; i++) ps2_bit(fr[i], 1'b0);
         bus.ps2_data = 1'b1;
         wait_cyc(HALF);
         bus.ps2_clk = 1'b0;
         lat = 0;
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.code_valid) begin
               lat = i;
               break;
            end
         end
         chk("latency posedges", lat, int'(FLEN) + 3);
         @(posedge clk);
         #1;
         chk("valid pulse width", int'(bus.code_valid), 0);
         wait_cyc(HALF);
         bus.ps2_clk = 1'b1;
         wait_cyc(60);
         model_frame(d, 1'b0, ev, ee);
         chk("latency valid_cnt", n_valid - v0, 1);
         chk("latency code", int'(bus.code), int'(m_code));
      end

      // Short low glitches in IDLE, then one inside a frame.
      v0 = n_valid;
      e0 = n_err;
      for (int i = 0; i < 3; i++) begin
         bus.ps2_clk = 1'b0;
         wait_cyc(3);
         bus.ps2_clk = 1'b1;
         wait_cyc(20);
      end
      wait_cyc(20);
      chk("idle glitch valid_cnt", n_valid - v0, 0);
      chk("idle glitch err_cnt", n_err - e0, 0);
      run_frame(8'h29, 1'b0, 4, "glitch 29");

      // Timeout after 5 bits; pending E0 must be dropped.
      run_frame(8'hE0, 1'b0, -1, "pre-timeout E0");
      v0 = n_valid;
      e0 = n_err;
      send_frame(8'h5A, 1'b0, 5, -1);
      t_end = cyc;
      wait_cyc(int'(TOUT) + 10);
      dly = err_cyc - (t_end - HALF);
      chk("timeout err_cnt", n_err - e0, 1);
      chk("timeout valid_cnt", n_valid - v0, 0);
      chk("timeout window", int'(dly >= int'(TOUT) && dly <= int'(TOUT) + 15), 1);
      m_ext_pend = 0;
      m_brk_pend = 0;
      run_frame(8'h5A, 1'b0, -1, "post-timeout 5A");

      // Reset mid-frame with a pending F0.
      run_frame(8'hF0, 1'b0, -1, "pre-reset F0");
      send_frame(8'h77, 1'b0, 6, -1);
      @(negedge clk);
      rst = 1'b1;
      bus.ps2_data = 1'b1;
      wait_cyc(3);
      chk("midreset code", int'(bus.code), 0);
      chk("midreset ext", int'(bus.ext), 0);
      chk("midreset brk", int'(bus.brk), 0);
      chk("midreset valid", int'(bus.code_valid), 0);
      chk("midreset err", int'(bus.frame_err), 0);
      rst = 1'b0;
      m_code = 8'h00;
      m_ext = 0;
      m_brk = 0;
      m_ext_pend = 0;
      m_brk_pend = 0;
      wait_cyc(30);
      run_frame(8'h1D, 1'b0, -1, "post-reset 1D");

      for (int i = 0; i < 24; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 2) d = 8'hE0;
         else if (r < 4) d = 8'hF0;
         else d = 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 5) == 0);
         run_frame(d, bp, -1, $sformatf("rand%0d d=%02h bp=%0d", i, d, bp));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
